// File: rtl/bram_bist_if.sv
// BRAM port bundle between the BIST engine (master) and the memory under test (slave).
interface bram_bist_if #(
    parameter int unsigned DATA_W = 32,
    parameter int unsigned ADDR_W = 8
) ();
    logic [ADDR_W-1:0] mem_addr;
    logic              mem_we;
    logic [DATA_W-1:0] mem_wdata;
    logic [DATA_W-1:0] mem_rdata;

    modport master (output mem_addr, output mem_we, output mem_wdata, input mem_rdata);
    modport slave  (input mem_addr, input mem_we, input mem_wdata, output mem_rdata);
endinterface

// File: rtl/bram_bist.sv
// Single-pass BRAM built-in self test: write a pattern to every address, read it back
// through a one-stage compare pipeline, and report error count and first failing address.
module bram_bist #(
    parameter int unsigned DATA_W = 32,
    parameter int unsigned ADDR_W = 8,
    parameter int unsigned ERR_W  = 16
) (
    input  logic              clk,
    input  logic              rst,
    input  logic              start,
    input  logic [1:0]        mode,
    bram_bist_if.master       mem,
    output logic              busy,
    output logic              done,
    output logic              pass,
    output logic [ERR_W-1:0]  err_count,
    output logic [ADDR_W-1:0] first_err_addr
);

    localparam logic [ADDR_W-1:0] LAST_ADDR = '1;
    localparam logic [ERR_W-1:0]  ERR_MAX   = '1;

    typedef enum logic [2:0] {
        S_IDLE  = 3'd0,
        S_WRITE = 3'd1,
        S_READ  = 3'd2,
        S_DRAIN = 3'd3,
        S_DONE  = 3'd4
    } state_e;

    state_e              state_q, state_d;
    logic [ADDR_W-1:0]   cnt_q, cnt_d;
    logic [1:0]          mode_q, mode_d;
    logic                cmp_valid_q, cmp_valid_d;
    logic [ADDR_W-1:0]   cmp_addr_q, cmp_addr_d;
    logic [ERR_W-1:0]    err_q, err_d;
    logic [ADDR_W-1:0]   first_q, first_d;
    logic                mem_we_q, mem_we_d;
    logic [ADDR_W-1:0]   mem_addr_q, mem_addr_d;
    logic [DATA_W-1:0]   mem_wdata_q, mem_wdata_d;
    logic                busy_q, busy_d;
    logic                done_q, done_d;
    logic                pass_q, pass_d;
    logic                active_d;

    // Expected data for a given pattern mode and address.
    function automatic logic [DATA_W-1:0] pattern(input logic [1:0] m, input logic [ADDR_W-1:0] a);
        logic [DATA_W-1:0] lin;
        logic [DATA_W-1:0] chk;
        logic [DATA_W-1:0] p;
        lin = DATA_W'(a);
        for (int i = 0; i < int'(DATA_W); i++) begin
            chk[i] = i[0] ^ a[0];
        end
        case (m)
            2'd0:    p = lin;
            2'd1:    p = '0;
            2'd2:    p = chk;
            default: p = ~lin;
        endcase
        return p;
    endfunction

    // Next-state, compare and output decode; outputs are registered from the next state.
    always_comb begin
        state_d     = state_q;
        cnt_d       = cnt_q;
        mode_d      = mode_q;
        err_d       = err_q;
        first_d     = first_q;
        cmp_valid_d = (state_q == S_READ);
        cmp_addr_d  = cnt_q;

        if (cmp_valid_q && (mem.mem_rdata != pattern(mode_q, cmp_addr_q))) begin
            if (err_q != ERR_MAX) begin
                err_d = err_q + ERR_W'(1);
            end
            if (err_q == '0) begin
                first_d = cmp_addr_q;
            end
        end

        case (state_q)
            S_IDLE, S_DONE: begin
                if (start) begin
                    state_d = S_WRITE;
                    mode_d  = mode;
                    cnt_d   = '0;
                    err_d   = '0;
                    first_d = '0;
                end
            end
            S_WRITE: begin
                cnt_d = cnt_q + ADDR_W'(1);
                if (cnt_q == LAST_ADDR) begin
                    state_d = S_READ;
                end
            end
            S_READ: begin
                cnt_d = cnt_q + ADDR_W'(1);
                if (cnt_q == LAST_ADDR) begin
                    state_d = S_DRAIN;
                end
            end
            S_DRAIN: state_d = S_DONE;
            default: state_d = S_IDLE;
        endcase

        active_d    = (state_d == S_WRITE) || (state_d == S_READ);
        busy_d      = active_d || (state_d == S_DRAIN);
        done_d      = (state_d == S_DONE);
        pass_d      = done_d && (err_d == '0);
        mem_we_d    = (state_d == S_WRITE);
        mem_addr_d  = active_d ? cnt_d : '0;
        mem_wdata_d = mem_we_d ? pattern(mode_d, cnt_d) : '0;
    end

    always_ff @(posedge clk) begin
        if (rst) begin
            state_q     <= S_IDLE;
            cnt_q       <= '0;
            mode_q      <= '0;
            cmp_valid_q <= 1'b0;
            cmp_addr_q  <= '0;
            err_q       <= '0;
            first_q     <= '0;
            mem_we_q    <= 1'b0;
            mem_addr_q  <= '0;
            mem_wdata_q <= '0;
            busy_q      <= 1'b0;
            done_q      <= 1'b0;
            pass_q      <= 1'b0;
        end else begin
            state_q     <= state_d;
            cnt_q       <= cnt_d;
            mode_q      <= mode_d;
            cmp_valid_q <= cmp_valid_d;
            cmp_addr_q  <= cmp_addr_d;
            err_q       <= err_d;
            first_q     <= first_d;
            mem_we_q    <= mem_we_d;
            mem_addr_q  <= mem_addr_d;
            mem_wdata_q <= mem_wdata_d;
            busy_q      <= busy_d;
            done_q      <= done_d;
            pass_q      <= pass_d;
        end
    end

    assign mem.mem_we      = mem_we_q;
    assign mem.mem_addr    = mem_addr_q;
    assign mem.mem_wdata   = mem_wdata_q;
    assign busy            = busy_q;
    assign done            = done_q;
    assign pass            = pass_q;
    assign err_count       = err_q;
    assign first_err_addr  = first_q;

endmodule

// File: tb/tb_bram_bist.sv
// Bench for bram_bist: two instances (16-bit and 1-bit error counters) against a
// 1-cycle BRAM model with per-address stuck/flip faults and a pattern-rule reference.
module tb_bram_bist;

    localparam int unsigned DATA_W = 32;
    localparam int unsigned ADDR_W = 4;
    localparam int unsigned DEPTH  = 16;

    logic       clk = 1'b0;
    logic       rst;
    logic       start;
    logic [1:0] mode;

    always #5 clk = ~clk;

    bram_bist_if #(.DATA_W(DATA_W), .ADDR_W(ADDR_W)) bus_a ();
    bram_bist_if #(.DATA_W(DATA_W), .ADDR_W(ADDR_W)) bus_b ();

    logic        busy_a, done_a, pass_a, busy_b, done_b, pass_b;
    logic [15:0] err_a;
    logic [0:0]  err_b;
    logic [3:0]  first_a, first_b;

    bram_bist #(.DATA_W(DATA_W), .ADDR_W(ADDR_W), .ERR_W(16)) dut_a (
        .clk(clk), .rst(rst), .start(start), .mode(mode), .mem(bus_a),
        .busy(busy_a), .done(done_a), .pass(pass_a),
        .err_count(err_a), .first_err_addr(first_a)
    );

    bram_bist #(.DATA_W(DATA_W), .ADDR_W(ADDR_W), .ERR_W(1)) dut_b (
        .clk(clk), .rst(rst), .start(start), .mode(mode), .mem(bus_b),
        .busy(busy_b), .done(done_b), .pass(pass_b),
        .err_count(err_b), .first_err_addr(first_b)
    );

    logic [31:0] mem_a     [DEPTH];
    logic [31:0] mem_b     [DEPTH];
    logic [31:0] or_mask   [DEPTH];
    logic [31:0] flip_mask [DEPTH];

    int checks   = 0;
    int failures = 0;

    // Registered-read BRAM with faults applied on the read path.
    always @(posedge clk) begin
        if (bus_a.mem_we) mem_a[bus_a.mem_addr] <= bus_a.mem_wdata;
        if (bus_b.mem_we) mem_b[bus_b.mem_addr] <= bus_b.mem_wdata;
        bus_a.mem_rdata <= (mem_a[bus_a.mem_addr] | or_mask[bus_a.mem_addr]) ^ flip_mask[bus_a.mem_addr];
        bus_b.mem_rdata <= (mem_b[bus_b.mem_addr] | or_mask[bus_b.mem_addr]) ^ flip_mask[bus_b.mem_addr];
    end

    function automatic logic [31:0] ref_pat(input logic [1:0] m, input int a);
        case (m)
            2'd0:    return 32'(a);
            2'd1:    return 32'h0;
            2'd2:    return (a % 2 == 0) ? 32'hAAAA_AAAA : 32'h5555_5555;
            default: return ~32'(a);
        endcase
    endfunction

    function automatic bool_bad(input logic [1:0] m, input int a);
        logic [31:0] p;
        p = ref_pat(m, a);
        return (((p | or_mask[a]) ^ flip_mask[a]) != p);
    endfunction

    function automatic int ref_errs(input logic [1:0] m);
        int n = 0;
        for (int a = 0; a < int'(DEPTH); a++) if (bool_bad(m, a)) n++;
        return n;
    endfunction

    function automatic int ref_first(input logic [1:0] m);
        for (int a = 0; a < int'(DEPTH); a++) if (bool_bad(m, a)) return a;
        return 0;
    endfunction

    task automatic clear_faults();
        for (int a = 0; a < int'(DEPTH); a++) begin
            or_mask[a]   = 32'h0;
            flip_mask[a] = 32'h0;
        end
    endtask

    // One complete run from a start pulse, checked against the reference.
    task automatic do_run(input logic [1:0] m, input bit noise, input string tag);
        int we_cnt, bad_wr, busy_cnt, bad_stat, cyc, exp_err, exp_first;
        bit got_done;
        we_cnt = 0; bad_wr = 0; busy_cnt = 0; bad_stat = 0; cyc = 0; got_done = 1'b0;
        exp_err   = ref_errs(m);
        exp_first = ref_first(m);
        @(negedge clk);
        start = 1'b1;
        mode  = m;
        while (!got_done && cyc < 200) begin
            @(negedge clk);
            cyc++;
            if (busy_a === 1'b1) busy_cnt++;
            if (busy_a === 1'b1 && (done_a !== 1'b0 || pass_a !== 1'b0)) bad_stat++;
            if (bus_a.mem_we === 1'b1) begin
                if (bus_a.mem_addr !== 4'(we_cnt) || bus_a.mem_wdata !== ref_pat(m, we_cnt)) bad_wr++;
                we_cnt++;
            end
            if (done_a === 1'b1) got_done = 1'b1;
            start = (noise && busy_cnt < 30) ? 1'($urandom_range(0, 1)) : 1'b0;
            if (noise) mode = 2'($urandom_range(0, 3));
        end
        checks++;
        if (!got_done) begin
            failures++; $display("FAIL %s done_timeout: no done within %0d cycles", tag, cyc);
        end
        checks++;
        if (we_cnt !== 16 || bad_wr !== 0) begin
            failures++; $display("FAIL %s writes: count %0d bad %0d, required 16 and 0", tag, we_cnt, bad_wr);
        end
        checks++;
        if (busy_cnt !== 33 || bad_stat !== 0) begin
            failures++; $display("FAIL %s busy: cycles %0d bad_status %0d, required 33 and 0", tag, busy_cnt, bad_stat);
        end
        checks++;
        if (err_a !== 16'(exp_err) || first_a !== 4'(exp_first) || pass_a !== (exp_err == 0)) begin
            failures++;
            $display("FAIL %s result: err %0d first %0d pass %b, required %0d %0d %b",
                     tag, err_a, first_a, pass_a, exp_err, exp_first, exp_err == 0);
        end
        checks++;
        if (err_b !== ((exp_err > 0) ? 1'b1 : 1'b0) || first_b !== 4'(exp_first) || done_b !== 1'b1) begin
            failures++;
            $display("FAIL %s sat_result: err %0d first %0d done %b, required %0d %0d 1",
                     tag, err_b, first_b, done_b, (exp_err > 0) ? 1 : 0, exp_first);
        end
        checks++;
        if (bus_a.mem_we !== 1'b0 || bus_a.mem_addr !== 4'h0 || bus_a.mem_wdata !== 32'h0 || busy_a !== 1'b0) begin
            failures++;
            $display("FAIL %s done_bus: we %b addr %0h wdata %0h busy %b, required all 0",
                     tag, bus_a.mem_we, bus_a.mem_addr, bus_a.mem_wdata, busy_a);
        end
    endtask

    task automatic test_reset();
        rst   = 1'b1;
        start = 1'b1;
        mode  = 2'($urandom_range(0, 3));
        repeat (2) @(negedge clk);
        checks++;
        if (bus_a.mem_we !== 1'b0 || bus_a.mem_addr !== 4'h0 || bus_a.mem_wdata !== 32'h0) begin
            failures++;
            $display("FAIL reset_bus: we %b addr %0h wdata %0h, required 0", bus_a.mem_we, bus_a.mem_addr, bus_a.mem_wdata);
        end
        checks++;
        if (busy_a !== 1'b0 || done_a !== 1'b0 || pass_a !== 1'b0 || err_a !== 16'h0 || first_a !== 4'h0) begin
            failures++;
            $display("FAIL reset_status: busy %b done %b pass %b err %0d first %0d, required 0",
                     busy_a, done_a, pass_a, err_a, first_a);
        end
        start = 1'b0;
        rst   = 1'b0;
        @(negedge clk);
        checks++;
        if (busy_a !== 1'b0 || bus_a.mem_we !== 1'b0 || busy_b !== 1'b0 || err_b !== 1'b0) begin
            failures++;
            $display("FAIL reset_start_ignored: busy %b we %b busy_b %b err_b %b, required 0",
                     busy_a, bus_a.mem_we, busy_b, err_b);
        end
    endtask

    task automatic test_mode0_clean();
        clear_faults();
        do_run(2'd0, 1'b0, "mode0_clean");
    endtask

    task automatic test_checkerboard_faults();
        clear_faults();
        or_mask[5] = 32'h1;
        do_run(2'd2, 1'b0, "chk_stuck_addr5");
        clear_faults();
        or_mask[6] = 32'h1;
        do_run(2'd2, 1'b0, "chk_stuck_addr6");
    endtask

    task automatic test_zero_two_faults();
        clear_faults();
        or_mask[3] = 32'hFFFF_FFFF;
        or_mask[9] = 32'hFFFF_FFFF;
        do_run(2'd1, 1'b0, "zero_two_faults");
        repeat (5) @(negedge clk);
        checks++;
        if (done_a !== 1'b1 || err_a !== 16'd2 || first_a !== 4'd3 || pass_a !== 1'b0) begin
            failures++;
            $display("FAIL done_hold: done %b err %0d first %0d pass %b, required 1 2 3 0",
                     done_a, err_a, first_a, pass_a);
        end
        clear_faults();
    endtask

    task automatic test_start_held();
        int cyc, we_cnt, bad_wr, busy_cnt;
        bit got_done;
        cyc = 0; we_cnt = 0; bad_wr = 0; busy_cnt = 0; got_done = 1'b0;
        clear_faults();
        @(negedge clk);
        start = 1'b1;
        mode  = 2'd0;
        while (!got_done && cyc < 200) begin
            @(negedge clk);
            cyc++;
            if (busy_a === 1'b1) busy_cnt++;
            if (bus_a.mem_we === 1'b1) begin
                if (bus_a.mem_addr !== 4'(we_cnt) || bus_a.mem_wdata !== ref_pat(2'd0, we_cnt)) bad_wr++;
                we_cnt++;
            end
            if (done_a === 1'b1) got_done = 1'b1;
            if (busy_cnt == 5) mode = 2'd3;
        end
        checks++;
        if (!got_done || we_cnt !== 16 || bad_wr !== 0 || pass_a !== 1'b1) begin
            failures++;
            $display("FAIL held_first_run: done %b writes %0d bad %0d pass %b, required 1 16 0 1",
                     got_done, we_cnt, bad_wr, pass_a);
        end
        @(negedge clk);
        checks++;
        if (bus_a.mem_we !== 1'b1 || bus_a.mem_addr !== 4'h0 || bus_a.mem_wdata !== 32'hFFFF_FFFF || busy_a !== 1'b1) begin
            failures++;
            $display("FAIL held_restart: we %b addr %0h wdata %0h busy %b, required 1 0 ffffffff 1",
                     bus_a.mem_we, bus_a.mem_addr, bus_a.mem_wdata, busy_a);
        end
        start = 1'b0;
        cyc = 0;
        while (done_a !== 1'b1 && cyc < 100) begin
            @(negedge clk);
            cyc++;
        end
        checks++;
        if (done_a !== 1'b1 || pass_a !== 1'b1 || err_a !== 16'h0) begin
            failures++;
            $display("FAIL held_second_run: done %b pass %b err %0d, required 1 1 0", done_a, pass_a, err_a);
        end
    endtask

    task automatic test_reset_mid();
        int cyc, busy_cnt;
        clear_faults();
        @(negedge clk);
        start = 1'b1;
        mode  = 2'($urandom_range(0, 3));
        @(negedge clk);
        start = 1'b0;
        cyc = 0;
        while (!(bus_a.mem_we === 1'b1 && bus_a.mem_addr === 4'd7) && cyc < 100) begin
            @(negedge clk);
            cyc++;
        end
        checks++;
        if (bus_a.mem_addr !== 4'd7) begin
            failures++; $display("FAIL reset_mid_reach: addr %0h, required 7", bus_a.mem_addr);
        end
        rst = 1'b1;
        @(negedge clk);
        checks++;
        if (bus_a.mem_we !== 1'b0 || busy_a !== 1'b0 || done_a !== 1'b0 || err_a !== 16'h0) begin
            failures++;
            $display("FAIL reset_mid_abort: we %b busy %b done %b err %0d, required 0",
                     bus_a.mem_we, busy_a, done_a, err_a);
        end
        rst = 1'b0;
        @(negedge clk);
        checks++;
        if (bus_a.mem_we !== 1'b0 || busy_a !== 1'b0) begin
            failures++; $display("FAIL reset_mid_idle: we %b busy %b, required 0", bus_a.mem_we, busy_a);
        end
        do_run(2'd0, 1'b0, "after_reset_run");

        // Abort in the drain cycle with a fault on the last address still in flight.
        flip_mask[15] = 32'h0000_0100;
        @(negedge clk);
        start = 1'b1;
        mode  = 2'd2;
        cyc = 0;
        busy_cnt = 0;
        while (busy_cnt < 33 && cyc < 100) begin
            @(negedge clk);
            cyc++;
            start = 1'b0;
            if (busy_a === 1'b1) busy_cnt++;
        end
        rst = 1'b1;
        @(negedge clk);
        rst = 1'b0;
        checks++;
        if (err_a !== 16'h0 || err_b !== 1'b0 || done_a !== 1'b0 || first_a !== 4'h0) begin
            failures++;
            $display("FAIL reset_drain: err %0d err_b %0d done %b first %0d, required 0",
                     err_a, err_b, done_a, first_a);
        end
        clear_faults();
    endtask

    task automatic test_random();
        for (int k = 0; k < 8; k++) begin
            int nf;
            logic [31:0] v;
            clear_faults();
            nf = int'($urandom_range(0, 3));
            for (int j = 0; j < nf; j++) begin
                v = $urandom;
                if (v == 32'h0) v = 32'h1;
                flip_mask[$urandom_range(0, DEPTH - 1)] = v;
            end
            do_run(2'($urandom_range(0, 3)), k[0], $sformatf("random_%0d", k));
        end
        clear_faults();
    endtask

    initial begin
        rst   = 1'b1;
        start = 1'b0;
        mode  = 2'd0;
        clear_faults();
        test_reset();
        test_mode0_clean();
        test_checkerboard_faults();
        test_zero_two_faults();
        test_reset();
        test_start_held();
        test_reset_mid();
        test_random();
        $display("TB_RESULT checks=%0d failures=%0d", checks, failures);
        $finish;
    end

endmodule
